// File: rtl/vector_scalar_div.sv
// Fixed-point 3-vector divided by a fixed-point scalar using three lock-stepped
// radix-2 restoring dividers; one operation in flight behind valid/ready handshakes.

package fixed_point;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned FRAC  = 16;
  typedef logic signed [WIDTH-1:0] fixed_point_t;
endpackage

package vector;
  typedef struct packed {
    fixed_point::fixed_point_t x;
    fixed_point::fixed_point_t y;
    fixed_point::fixed_point_t z;
  } vector_t;
endpackage

module vector_scalar_div
  import fixed_point::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  fixed_point_t   scalar_op,
  input  vector::vector_t vector_op,
  output logic           out_valid,
  input  logic           out_ready,
  output vector::vector_t result,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int unsigned ITER = WIDTH + FRAC;
  localparam int unsigned CW   = $clog2(ITER);
  localparam fixed_point_t      MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam fixed_point_t      MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  ONE     = WIDTH'(1);
  localparam logic [ITER-1:0]   POS_LIM = ITER'(MAX_POS);
  localparam logic [ITER-1:0]   NEG_LIM = POS_LIM + ITER'(1);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic             in_ready_nxt, out_valid_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] den;
  logic             scal_neg;
  logic [2:0]       comp_neg;
  logic [ITER-1:0]  dq      [3];
  logic [WIDTH-1:0] rem     [3];
  logic [ITER-1:0]  dq_nxt  [3];
  logic [WIDTH-1:0] rem_nxt [3];
  logic [WIDTH:0]   trial   [3];
  fixed_point_t     comp    [3];
  fixed_point_t     fix_res [3];
  logic [2:0]       fix_ovf;
  logic             den_zero;

  function automatic logic [WIDTH-1:0] abs_mag(input fixed_point_t v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + ONE) : u;
  endfunction

  assign comp[0]  = vector_op.x;
  assign comp[1]  = vector_op.y;
  assign comp[2]  = vector_op.z;
  assign den_zero = (den == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; handshake outputs are registered copies of the next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (scalar_op == '0) ? FIX : DIV;
      DIV:  if (cnt == CW'(ITER-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

  // One restoring step per axis: dq shifts dividend bits out and quotient bits in
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      trial[a]   = {rem[a], dq[a][ITER-1]};
      rem_nxt[a] = rem[a];
      dq_nxt[a]  = {dq[a][ITER-2:0], 1'b0};
      if (trial[a] >= {1'b0, den}) begin
        rem_nxt[a] = WIDTH'(trial[a] - {1'b0, den});
        dq_nxt[a]  = {dq[a][ITER-2:0], 1'b1};
      end else begin
        rem_nxt[a] = WIDTH'(trial[a]);
      end
    end
  end

  // Sign application and saturation of the magnitude quotients
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      fix_res[a] = '0;
      fix_ovf[a] = 1'b0;
      if (den_zero) begin
        fix_ovf[a] = 1'b1;
        if (dq[a] != '0) fix_res[a] = comp_neg[a] ? MIN_NEG : MAX_POS;
      end else if (comp_neg[a] ^ scal_neg) begin
        if (dq[a] > NEG_LIM) begin
          fix_res[a] = MIN_NEG;
          fix_ovf[a] = 1'b1;
        end else begin
          fix_res[a] = ~dq[a][WIDTH-1:0] + ONE;
        end
      end else begin
        if (dq[a] > POS_LIM) begin
          fix_res[a] = MAX_POS;
          fix_ovf[a] = 1'b1;
        end else begin
          fix_res[a] = dq[a][WIDTH-1:0];
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      den         <= '0;
      scal_neg    <= 1'b0;
      comp_neg    <= '0;
      for (int a = 0; a < 3; a++) begin
        dq[a]  <= '0;
        rem[a] <= '0;
      end
    end else begin
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      case (state)
        IDLE: if (in_valid) begin
          den      <= abs_mag(scalar_op);
          scal_neg <= scalar_op[WIDTH-1];
          cnt      <= '0;
          for (int a = 0; a < 3; a++) begin
            comp_neg[a] <= comp[a][WIDTH-1];
            dq[a]       <= {abs_mag(comp[a]), FRAC'(0)};
            rem[a]      <= '0;
          end
        end
        DIV: begin
          cnt <= cnt + CW'(1);
          for (int a = 0; a < 3; a++) begin
            dq[a]  <= dq_nxt[a];
            rem[a] <= rem_nxt[a];
          end
        end
        FIX: begin
          result.x    <= fix_res[0];
          result.y    <= fix_res[1];
          result.z    <= fix_res[2];
          overflow    <= |fix_ovf;
          div_by_zero <= den_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vector_scalar_div.md
# vector_scalar_div

Divides each component of a fixed-point 3-vector by a fixed-point scalar: result = vector_op / scalar_op. It is the inverse of vector_scalar_mul in the vector_math library and is used wherever the pipeline normalises or un-scales vectors. Three radix-2 restoring dividers run in lock-step, one per axis, behind a single valid/ready handshake on each side. Division takes multiple cycles, so the block accepts one operation at a time.

## Interface
- WIDTH, 32: bit width of fixed_point::fixed_point_t, signed two's complement.
- FRAC, 16: fractional bits of fixed_point::fixed_point_t (Q16.16 by default).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept; high only in IDLE.
- scalar_op  in  fixed_point::fixed_point_t  divisor.
- vector_op  in  vector::vector_t  dividend; fields x, y, z.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- result  out  vector::vector_t  quotient vector; registered.
- overflow  out  1  OR over axes of saturation, including divide-by-zero.
- div_by_zero  out  1  scalar_op was 0 for this result.

## Operation
- States: IDLE, DIV, FIX, DONE.
- IDLE, in_ready=1:
  - On in_valid, latch |scalar_op| and per-axis |component| and signs.
  - Clear the iteration counter.
  - Go to DIV, or to FIX if scalar_op==0.
- DIV:
  - Per axis, the dividend is |component| << FRAC, width WIDTH+FRAC.
  - One restoring step per cycle, MSB first. The remainder is WIDTH+1 bits and the quotient WIDTH+FRAC bits.
  - The counter runs 0..ITER-1, where ITER=WIDTH+FRAC (48 by default).
  - After the step with counter==ITER-1, go to FIX.
- FIX registers result, overflow and div_by_zero, then goes to DONE.
  - Sign: negate the magnitude quotient if the component sign differs from the scalar sign. This rounds toward zero.
  - Saturation, positive result: magnitude > 2^(WIDTH-1)-1 gives 0x7FFF_FFFF and sets that axis's overflow.
  - Saturation, negative result: magnitude > 2^(WIDTH-1) gives 0x8000_0000 and sets that axis's overflow.
  - Divide-by-zero, per axis: component >0 gives max positive, <0 gives min negative, ==0 gives 0. div_by_zero=1 and overflow=1.
- DONE, out_valid=1:
  - result and flags are stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored.
- Magnitudes are held as WIDTH-bit unsigned, so an operand of 0x8000_0000 (magnitude 2^(WIDTH-1)) is exact.
- Reset:
  - state=IDLE, out_valid=0, result=0 on all axes, overflow=0, div_by_zero=0, counter=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation aborts the operation; no stale result is ever presented.

## Timing
- Acceptance is the edge with in_valid && in_ready. Call it E0.
- Normal divide:
  - Edges E1..E48 perform the iterations.
  - E49 is the FIX register; out_valid is high after E49.
  - Latency is ITER+1 = 49 cycles.
- Divide-by-zero: E0 goes to FIX, and out_valid is high after E1.
- Output release:
  - Edge with out_valid && out_ready: out_valid goes low, in_ready goes high.
  - The earliest next acceptance is the following edge.
  - Throughput is one operation per ITER+3 cycles.
- result and the flags hold their last values after release until the next FIX.
- in_ready and out_valid are never high together.
- in_ready is a pure decode of state; there is no combinational path from any input to any output.

## Test plan
- (2.0, -3.0, 0.5) / 2.0 (0x00020000):
  - result = (0x00010000, 0xFFFE8000, 0x00004000); overflow=0, div_by_zero=0.
  - out_valid exactly 49 cycles after acceptance.
- (1.0, -1.0, 0) / 3.0 (0x00030000):
  - result = (0x00005555, 0xFFFFAAAB, 0x00000000).
  - Rounding toward zero is confirmed on both signs.
- (0x7FFF0000, 0x80000000, 0x00010000) / 0.5 (0x00008000):
  - result = (0x7FFFFFFF, 0x80000000, 0x00020000), overflow=1.
  - Same vector / -1.0 gives y = 0x7FFFFFFF with overflow=1.
- (1.0, -1.0, 0) / 0:
  - result = (0x7FFFFFFF, 0x80000000, 0), div_by_zero=1, overflow=1.
  - out_valid after 1 cycle.
- Backpressure:
  - Hold out_ready=0 for 10 cycles while in_valid=1 with new operands.
  - result stays stable and in_ready stays 0.
  - After out_ready pulses, the second operation is accepted one cycle later and completes correctly.
- Mid-operation reset:
  - Assert rst 20 cycles into DIV.
  - Next cycle: out_valid=0, in_ready=1, result=0.
  - A new operation (4.0,4.0,4.0)/2.0 gives 0x00020000 on all axes.
